fc_classifier: RTL and testbench
================================

// Module: fc_classifier
// PURPOSE
//  Fully-connected output stage directly downstream of the 2x2 max-pool stage.
//  Snapshots the 3x3x3 pooled feature map (27 unsigned bytes) on the pool's valid edge.
//  Runs a serial MAC over the 27 inputs for NOUT neurons in parallel, then requantizes each to signed 8 bit.
//  Finds the arg-max class sequentially and pulses out_vld when fc_out and class_idx are ready.
// PARAMETERS
//  NOUT   10  number of output neurons/classes (2..16)
//  SHIFT  4   arithmetic right shift applied to accumulators before saturation (0..15)
//  ACC_W  24  signed accumulator width; must hold 27*255*128 + 2^15
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_vld     in   1          pool out_vld (level); a rising edge starts one inference
//  pool_lin   in   216        27 x u8; byte i = pool_lin[i*8+:8], i = ch*9+row*3+col
//  weight     in   NOUT*216   s8; w[j][i] = weight[(j*27+i)*8+:8]; static during operation
//  bias       in   NOUT*16    s16; b[j] = bias[j*16+:16]; static during operation
//  fc_out     out  NOUT*8     s8 requantized neuron outputs; y[j] = fc_out[j*8+:8]
//  class_idx  out  4          index of the maximum y[j]
//  out_vld    out  1          one-cycle pulse: fc_out/class_idx valid
//  busy       out  1          high while an inference is in progress (states MAC..ARGMAX)
// BEHAVIOUR
//  Reset: all outputs, in_vld_d, x buffer, accumulators, counters = 0; state IDLE. Reset mid-operation aborts it; no out_vld.
//  start = in_vld & ~in_vld_d, where in_vld_d is in_vld registered.
//   - in_vld high at the first edge after reset counts as a start.
//   - in_vld held high never restarts.
//  FSM: IDLE -> MAC -> QUANT -> ARGMAX -> IDLE.
//  Let E0 = the edge that samples start in IDLE.
//   - E0: x[0..26] <= pool_lin (pool may change after); acc[j] <= sext(b[j]); idx <= 0; -> MAC.
//   - E1..E27 (MAC): acc[j] += $signed({1'b0,x[idx]}) * w[j][idx] for all j; idx++. At idx==26 -> QUANT.
//   - E28 (QUANT): q = acc[j] >>> SHIFT (floor); y[j] = q>127 ? 127 : q<-128 ? -128 : q[7:0].
//     fc_out <= y; best_v <= y[0]; best_i <= 0; k <= 1; -> ARGMAX.
//   - E29..E27+NOUT (ARGMAX): one compare per edge, k = 1..NOUT-1.
//     If y[k] > best_v (strict, signed): best_v <= y[k], best_i <= k.
//   - Last ARGMAX edge (E27+NOUT): class_idx <= final best (including any update from compare k=NOUT-1); out_vld <= 1; -> IDLE.
//  out_vld: high for exactly one cycle, from E27+NOUT to E28+NOUT; latency = NOUT+27 cycles after E0.
//  busy: 1 from E0 to E27+NOUT; 0 in IDLE (low in the out_vld cycle).
//  fc_out and class_idx hold their values until the next QUANT / final ARGMAX edge.
//   - fc_out changes at QUANT, before out_vld; treat it as valid only from out_vld on.
//  Starts while busy are ignored: no queueing, no restart, in-flight result unaffected.
//  A start sampled at E28+NOUT (IDLE again) begins a new inference; back-to-back with a one-cycle gap.
//  All multiplies are signed 9x8 (17 bit), sign-extended to ACC_W; no overflow possible at ACC_W=24.
// TESTING  (NOUT=10, SHIFT=4)
//  1 x[i]=1, w[j][i]=j-5, b=0 -> acc[j]=27*(j-5); y9=6, y0=-9 (floor); class_idx=9.
//    out_vld high exactly at E37..E38.
//  2 x=255, w[0][*]=127, w[1][*]=-128, others 0, b=0 -> y0=127, y1=-128 (saturated); class_idx=0.
//  3 w=0, b[j]=16 for all j -> y[j]=1 all; tie -> class_idx=0.
//  4 in_vld held high 100 cycles -> exactly one out_vld. Drop and re-raise in_vld at E10 -> ignored, still one out_vld at E37.
//    pool_lin changed after E0 -> result unchanged.
//  5 Assert rst_n=0 at E15 -> all outputs 0, busy 0, no out_vld. Then case 1 -> identical result to test 1.
//  6 Second start sampled at E38 with different data -> second out_vld at E75 with the correct second result.
//    First result held E38..E65.

Source files
------------

// File: rtl/fc_classifier_if.sv
// Streaming handshake between the max-pool stage and the FC classifier.
interface fc_classifier_if #(
  parameter int NOUT = 10
);
  logic              in_vld;
  logic [215:0]      pool_lin;
  logic [NOUT*8-1:0] fc_out;
  logic [3:0]        class_idx;
  logic              out_vld;
  logic              busy;

  modport master (
    output in_vld, pool_lin,
    input  fc_out, class_idx, out_vld, busy
  );

  modport slave (
    input  in_vld, pool_lin,
    output fc_out, class_idx, out_vld, busy
  );
endinterface

// File: rtl/fc_classifier.sv
// Fully-connected output stage: serial 27-tap MAC for NOUT neurons, requantize
// to s8, then sequential arg-max; out_vld pulses NOUT+27 cycles after the start.
module fc_classifier #(
  parameter int NOUT  = 10,
  parameter int SHIFT = 4,
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fc_classifier_if.slave       io,
  input  logic [NOUT*216-1:0]  weight,
  input  logic [NOUT*16-1:0]   bias
);

  typedef enum logic [1:0] {IDLE, MAC, QUANT, ARGMAX} state_e;

  localparam logic signed [ACC_W-1:0] Q_MAX = 127;
  localparam logic signed [ACC_W-1:0] Q_MIN = -128;

  state_e                  state_q, state_d;
  logic                    in_vld_q;
  logic [7:0]              x_q   [27];
  logic [7:0]              x_d   [27];
  logic signed [ACC_W-1:0] acc_q [NOUT];
  logic signed [ACC_W-1:0] acc_d [NOUT];
  logic [4:0]              idx_q, idx_d;
  logic [3:0]              k_q, k_d;
  logic [3:0]              best_i_q, best_i_d;
  logic signed [7:0]       best_v_q, best_v_d;
  logic [3:0]              class_idx_q, class_idx_d;
  logic [NOUT*8-1:0]       fc_out_q, fc_out_d;
  logic                    out_vld_q, out_vld_d;

  logic                    start;
  logic                    last_cmp;
  logic [NOUT*8-1:0]       y_sat;
  logic signed [ACC_W-1:0] q;
  logic signed [7:0]       w_b;
  logic signed [16:0]      prod;
  logic signed [7:0]       y_k;

  assign start    = io.in_vld & ~in_vld_q;
  assign last_cmp = (k_q == 4'(NOUT-1));

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_vld_q    <= 1'b0;
      x_q         <= '{default: '0};
      acc_q       <= '{default: '0};
      idx_q       <= '0;
      k_q         <= '0;
      best_i_q    <= '0;
      best_v_q    <= '0;
      class_idx_q <= '0;
      fc_out_q    <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_vld_q    <= io.in_vld;
      x_q         <= x_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      best_i_q    <= best_i_d;
      best_v_q    <= best_v_d;
      class_idx_q <= class_idx_d;
      fc_out_q    <= fc_out_d;
      out_vld_q   <= out_vld_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (idx_q == 5'd26) state_d = QUANT;
      QUANT:   state_d = ARGMAX;
      ARGMAX:  if (last_cmp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Floor shift and saturate every accumulator to s8
  always_comb begin
    y_sat = '0;
    q     = '0;
    for (int unsigned j = 0; j < NOUT; j++) begin
      q = acc_q[j] >>> SHIFT;
      if (q > Q_MAX)      y_sat[j*8 +: 8] = 8'h7f;
      else if (q < Q_MIN) y_sat[j*8 +: 8] = 8'h80;
      else                y_sat[j*8 +: 8] = q[7:0];
    end
  end

  // Output/datapath logic
  always_comb begin
    x_d         = x_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    k_d         = k_q;
    best_i_d    = best_i_q;
    best_v_d    = best_v_q;
    class_idx_d = class_idx_q;
    fc_out_d    = fc_out_q;
    out_vld_d   = 1'b0;
    w_b         = '0;
    prod        = '0;
    y_k         = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int unsigned i = 0; i < 27; i++) x_d[i] = io.pool_lin[i*8 +: 8];
          for (int unsigned j = 0; j < NOUT; j++)
            acc_d[j] = {{(ACC_W-16){bias[j*16+15]}}, bias[j*16 +: 16]};
          idx_d = '0;
        end
      end
      MAC: begin
        for (int unsigned j = 0; j < NOUT; j++) begin
          w_b      = weight[(j*27 + 32'(idx_q))*8 +: 8];
          prod     = $signed({1'b0, x_q[idx_q]}) * w_b;
          acc_d[j] = acc_q[j] + {{(ACC_W-17){prod[16]}}, prod};
        end
        idx_d = idx_q + 5'd1;
      end
      QUANT: begin
        fc_out_d = y_sat;
        best_v_d = y_sat[7:0];
        best_i_d = '0;
        k_d      = 4'd1;
      end
      ARGMAX: begin
        // The final compare feeds class_idx directly so its update is not lost
        y_k = fc_out_q[32'(k_q)*8 +: 8];
        if (y_k > best_v_q) begin
          best_v_d = y_k;
          best_i_d = k_q;
        end
        k_d = k_q + 4'd1;
        if (last_cmp) begin
          class_idx_d = (y_k > best_v_q) ? k_q : best_i_q;
          out_vld_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign io.busy      = (state_q != IDLE);
  assign io.fc_out    = fc_out_q;
  assign io.class_idx = class_idx_q;
  assign io.out_vld   = out_vld_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Directed-vector bench for fc_classifier (NOUT=10, SHIFT=4).
module tb_fc_classifier;
  localparam int NOUT  = 10;
  localparam int SHIFT = 4;
  localparam int ACC_W = 24;
  localparam int NV    = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [NOUT*216-1:0] weight = '0;
  logic [NOUT*16-1:0]  bias   = '0;

  fc_classifier_if #(.NOUT(NOUT)) io ();

  fc_classifier #(.NOUT(NOUT), .SHIFT(SHIFT), .ACC_W(ACC_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io     (io.slave),
    .weight (weight),
    .bias   (bias)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [215:0]        pool;
    logic [NOUT*216-1:0] w;
    logic [NOUT*16-1:0]  b;
    logic [NOUT*8-1:0]   exp_y;
    logic [3:0]          exp_cls;
  } vec_t;

  vec_t vecs [NV];

  int y0 [NOUT] = '{-9, -7, -6, -4, -2, 0, 1, 3, 5, 6};
  int y1 [NOUT] = '{127, -128, 0, 0, 0, 0, 0, 0, 0, 0};
  int b3 [NOUT] = '{-80, 48, 48, 112, 112, -1, 0, 0, 0, 0};
  int y3 [NOUT] = '{-5, 3, 3, 7, 7, -1, 0, 0, 0, 0};

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [NOUT*8-1:0] act, input logic [NOUT*8-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int v);
    @(negedge clk);
    weight      = vecs[v].w;
    bias        = vecs[v].b;
    io.pool_lin = vecs[v].pool;
  endtask

  // Raise in_vld, take E0, then observe 45 edges sampled 1 time unit after each edge.
  task automatic watch(input int glitch_at, input int rst_at, input bit scramble,
                       output int first, output int pulses, output logic busy1,
                       output logic busyv, output logic [NOUT*8-1:0] y, output logic [3:0] cls);
    first = -1; pulses = 0; busy1 = 1'b0; busyv = 1'b1; y = '0; cls = '0;
    @(negedge clk);
    io.in_vld = 1'b1;
    @(posedge clk);
    #1;
    if (scramble) io.pool_lin = 216'({7{$urandom}});
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) busy1 = io.busy;
      if (io.out_vld) begin
        pulses++;
        if (first < 0) begin
          first = n; busyv = io.busy; y = io.fc_out; cls = io.class_idx;
        end
      end
      if (n == glitch_at - 1) io.in_vld = 1'b0;
      if (n == glitch_at)     io.in_vld = 1'b1;
      if (n == rst_at) begin
        rst_n = 1'b0;
        io.in_vld = 1'b0;
        #1;
        check("abort_out_vld", io.out_vld, 0);
        check("abort_busy", io.busy, 0);
        check("abort_class", io.class_idx, 0);
        check("abort_fc_out", io.fc_out, 0);
      end
      if (rst_at > 0 && n == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  task automatic run_vec(input int v, input string tag);
    int first, pulses;
    logic busy1, busyv;
    logic [NOUT*8-1:0] y;
    logic [3:0] cls;
    apply(v);
    watch(0, 0, 1'b0, first, pulses, busy1, busyv, y, cls);
    check({tag, "_latency"}, first, 37);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_busy_e1"}, busy1, 1);
    check({tag, "_busy_at_vld"}, busyv, 0);
    check({tag, "_fc_out"}, y, vecs[v].exp_y);
    check({tag, "_class"}, cls, vecs[v].exp_cls);
    @(negedge clk);
    io.in_vld = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int first, pulses, extra, hold_bad, p, n1, n2;
    logic busy1, busyv;
    logic [NOUT*8-1:0] y, y2;
    logic [3:0] cls, cls2;

    vecs = '{default: '0};
    for (int j = 0; j < NOUT; j++) begin
      for (int i = 0; i < 27; i++) begin
        vecs[0].w[(j*27+i)*8 +: 8] = 8'(j - 5);
        if (j == 0) vecs[1].w[(j*27+i)*8 +: 8] = 8'd127;
        if (j == 1) vecs[1].w[(j*27+i)*8 +: 8] = 8'h80;
        vecs[4].w[(j*27+i)*8 +: 8] = (i == 26) ? 8'd2 : 8'd1;
      end
      vecs[2].b[j*16 +: 16] = 16'd16;
      vecs[3].b[j*16 +: 16] = 16'(b3[j]);
      vecs[4].b[j*16 +: 16] = 16'(-16 * j);
      vecs[0].exp_y[j*8 +: 8] = 8'(y0[j]);
      vecs[1].exp_y[j*8 +: 8] = 8'(y1[j]);
      vecs[2].exp_y[j*8 +: 8] = 8'd1;
      vecs[3].exp_y[j*8 +: 8] = 8'(y3[j]);
      vecs[4].exp_y[j*8 +: 8] = 8'(23 - j);
    end
    for (int i = 0; i < 27; i++) begin
      vecs[0].pool[i*8 +: 8] = 8'd1;
      vecs[1].pool[i*8 +: 8] = 8'd255;
      vecs[2].pool[i*8 +: 8] = 8'(i * 9);
      vecs[3].pool[i*8 +: 8] = 8'(255 - i);
      vecs[4].pool[i*8 +: 8] = 8'(i);
    end
    vecs[0].exp_cls = 4'd9;
    vecs[1].exp_cls = 4'd0;
    vecs[2].exp_cls = 4'd0;
    vecs[3].exp_cls = 4'd3;
    vecs[4].exp_cls = 4'd0;

    io.in_vld   = 1'b0;
    io.pool_lin = '0;
    repeat (3) @(negedge clk);
    check("rst_out_vld", io.out_vld, 0);
    check("rst_busy", io.busy, 0);
    check("rst_class", io.class_idx, 0);
    check("rst_fc_out", io.fc_out, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) run_vec(v, $sformatf("vec%0d", v));

    // in_vld held high ~100 cycles with a drop/re-raise at E10 and pool changed after E0
    apply(0);
    watch(10, 0, 1'b1, first, pulses, busy1, busyv, y, cls);
    extra = 0;
    repeat (55) begin
      @(posedge clk);
      #1;
      if (io.out_vld) extra++;
    end
    check("hold_latency", first, 37);
    check("hold_pulses", pulses + extra, 1);
    check("hold_fc_out", y, vecs[0].exp_y);
    check("hold_class", cls, vecs[0].exp_cls);
    @(negedge clk);
    io.in_vld = 1'b0;
    repeat (3) @(negedge clk);

    // Reset at E15 aborts with no out_vld, then a clean rerun of vector 0
    apply(0);
    watch(0, 15, 1'b0, first, pulses, busy1, busyv, y, cls);
    check("abort_pulses", pulses, 0);
    repeat (2) @(negedge clk);
    run_vec(0, "after_abort");

    // Back-to-back: second start sampled at E38
    apply(0);
    @(negedge clk);
    io.in_vld = 1'b1;
    @(posedge clk);
    #1;
    p = 0; n1 = -1; n2 = -1; hold_bad = 0; y2 = '0; cls2 = '0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      if (io.out_vld) begin
        p++;
        if (n1 < 0) n1 = n;
        else if (n2 < 0) begin
          n2 = n; y2 = io.fc_out; cls2 = io.class_idx;
        end
      end
      if (n >= 38 && n <= 65 &&
          (io.fc_out !== vecs[0].exp_y || io.class_idx !== vecs[0].exp_cls)) hold_bad++;
      if (n == 36) io.in_vld = 1'b0;
      if (n == 37) begin
        io.in_vld   = 1'b1;
        weight      = vecs[1].w;
        bias        = vecs[1].b;
        io.pool_lin = vecs[1].pool;
      end
    end
    check("b2b_first_at", n1, 37);
    check("b2b_second_at", n2, 75);
    check("b2b_pulses", p, 2);
    check("b2b_first_held", hold_bad, 0);
    check("b2b_fc_out", y2, vecs[1].exp_y);
    check("b2b_class", cls2, vecs[1].exp_cls);
    @(negedge clk);
    io.in_vld = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
